// File: rtl/cache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU.
// Processor side is a 32-bit word port; memory side moves whole 128-bit blocks.
module cache_2way #(
  parameter int unsigned SETS = 4
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SETS-1:0][1:0] valid;
  logic [SETS-1:0][1:0] dirty;
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tag_arr  [SETS][2];
  logic [127:0]         data_arr [SETS][2];
  logic                 victim;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic             hit0, hit1, hit, hit_way, req, victim_sel;
  logic [127:0]     hit_block;

  assign idx        = proc_addr[IDX_W+1:2];
  assign tag        = proc_addr[29:IDX_W+2];
  assign off        = proc_addr[1:0];
  assign hit0       = valid[idx][0] && (tag_arr[idx][0] == tag);
  assign hit1       = valid[idx][1] && (tag_arr[idx][1] == tag);
  assign hit        = hit0 | hit1;
  assign hit_way    = ~hit0;
  assign hit_block  = data_arr[idx][hit_way];
  assign req        = proc_read | proc_write;
  // Fill invalid ways first (way 0 preferred), otherwise evict the LRU way
  assign victim_sel = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req && !hit)
          state_next = (valid[idx][victim_sel] && dirty[idx][victim_sel]) ? WRITE_BACK : ALLOCATE;
      end
      WRITE_BACK: if (mem_ready) state_next = ALLOCATE;
      ALLOCATE:   if (mem_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock
  always_comb begin
    proc_rdata = '0;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!proc_reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            proc_stall = ~hit;
            if (hit) proc_rdata = hit_block[{off, 5'd0} +: 32];
          end
        end
        WRITE_BACK: begin
          proc_stall = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {tag_arr[idx][victim], idx};
          mem_wdata  = data_arr[idx][victim];
        end
        ALLOCATE: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = proc_addr[29:2];
        end
        default: ;
      endcase
    end
  end

  // Line metadata: valid/dirty/lru and the victim frozen at miss detection
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid  <= '0;
      dirty  <= '0;
      lru    <= '0;
      victim <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
              if (proc_write) dirty[idx][hit_way] <= 1'b1;
            end else begin
              victim <= victim_sel;
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            valid[idx][victim] <= 1'b1;
            dirty[idx][victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; validity is tracked above
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && proc_write) begin
      data_arr[idx][hit_way][{off, 5'd0} +: 32] <= proc_wdata;
    end else if (state == ALLOCATE && mem_ready) begin
      data_arr[idx][victim] <= mem_rdata;
      tag_arr[idx][victim]  <= tag;
    end
  end

endmodule

// File: tb/tb_cache_2way.sv
// Randomized bench for cache_2way: a block-level residency/LRU model plus a
// backing memory predicts hits, write-backs, fills and returned words.
module tb_cache_2way;
  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  cache_2way #(.SETS(4)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: per set up to two resident blocks, index 0 = least recently used
  logic [27:0]  res_blk [4][2];
  int           res_cnt [4];
  logic [127:0] line_data [logic [27:0]];
  bit           dirty_b   [logic [27:0]];
  logic [127:0] backing   [logic [27:0]];
  logic [25:0]  tag_pool  [5];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit resident(input int s, input logic [27:0] b);
    for (int i = 0; i < res_cnt[s]; i++)
      if (res_blk[s][i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic get_block(input logic [27:0] b, output logic [127:0] d);
    if (!backing.exists(b)) backing[b] = {$urandom, $urandom, $urandom, $urandom};
    d = backing[b];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) res_cnt[i] = 0;
    line_data.delete();
    dirty_b.delete();
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, 128'({proc_stall, mem_read, mem_write, mem_addr, proc_rdata}), 128'(0));
    check({tag, "_wdata"}, mem_wdata, 128'(0));
  endtask

  // Hold the request a random number of cycles, then pulse mem_ready once
  task automatic mem_wait(input logic [1:0] rw_exp);
    int lat;
    lat = $urandom_range(0, 2);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("mem_hold", 128'({mem_read, mem_write}), 128'(rw_exp));
      check("mem_hold_stall", 128'(proc_stall), 128'(1));
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One processor request, called at posedge+1; returns at the next posedge+1
  task automatic access(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wd);
    logic [27:0]  b, v;
    logic [127:0] blkd, ld;
    int s, o;
    bit hit, evict, wb;
    b     = addr[29:2];
    s     = int'(addr[3:2]);
    o     = int'(addr[1:0]);
    hit   = resident(s, b);
    evict = !hit && (res_cnt[s] == 2);
    v     = res_blk[s][0];
    wb    = evict && dirty_b.exists(v) && dirty_b[v];
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wd;
    @(negedge clk);
    if (!hit) begin
      check("miss_stall", 128'(proc_stall), 128'(1));
      check("miss_detect_mem", 128'({mem_read, mem_write}), 128'(0));
      check("miss_rdata", 128'(proc_rdata), 128'(0));
      @(negedge clk);
      if (wb) begin
        check("wb_req", 128'({mem_read, mem_write}), 128'(2'b01));
        check("wb_addr", 128'(mem_addr), 128'(v));
        check("wb_data", mem_wdata, line_data[v]);
        backing[v] = line_data[v];
        mem_wait(2'b01);
      end
      if (evict) begin
        line_data.delete(v);
        dirty_b.delete(v);
        res_blk[s][0] = res_blk[s][1];
        res_blk[s][1] = b;
      end else begin
        res_blk[s][res_cnt[s]] = b;
        res_cnt[s]++;
      end
      check("alloc_req", 128'({mem_read, mem_write}), 128'(2'b10));
      check("alloc_addr", 128'(mem_addr), 128'(b));
      check("alloc_stall", 128'(proc_stall), 128'(1));
      get_block(b, blkd);
      mem_rdata    = blkd;
      line_data[b] = blkd;
      dirty_b[b]   = 1'b0;
      mem_wait(2'b10);
    end else if (res_cnt[s] == 2 && res_blk[s][0] == b) begin
      res_blk[s][0] = res_blk[s][1];
      res_blk[s][1] = b;
    end
    check("hit_stall", 128'(proc_stall), 128'(0));
    check("hit_mem", 128'({mem_read, mem_write}), 128'(0));
    ld = line_data[b];
    check("rdata", 128'(proc_rdata), 128'(ld[o*32 +: 32]));
    if (wr) begin
      ld[o*32 +: 32] = wd;
      line_data[b]   = ld;
      dirty_b[b]     = 1'b1;
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  // No request: nothing moves, and a stray mem_ready is ignored
  task automatic idle_cycle();
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'($urandom);
    mem_ready  = 1'b1;
    @(negedge clk);
    check_outs_zero("idle");
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    #1;
    check_outs_zero("reset_outs");
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [29:0] a;
    int mode;
    tag_pool[0] = 26'h0;
    tag_pool[1] = 26'h1;
    tag_pool[2] = 26'h2;
    tag_pool[3] = 26'h3;
    tag_pool[4] = 26'h3FFFFFF;
    proc_reset = 1'b1;
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    model_clear();
    #2;
    check_outs_zero("por_outs");
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    proc_read  = 1'b0;

    // Clean miss then conflicting block in the same set; both stay resident
    access(1'b1, 1'b0, 30'h000, 32'h0);
    access(1'b1, 1'b0, 30'h010, 32'h0);
    access(1'b1, 1'b0, 30'h000, 32'h0);
    access(1'b1, 1'b0, 30'h010, 32'h0);

    // Dirty LRU victim is written back before the fill
    do_reset();
    access(1'b0, 1'b1, 30'h000, 32'hAAAA5555);
    access(1'b1, 1'b0, 30'h010, 32'h0);
    access(1'b1, 1'b0, 30'h020, 32'h0);
    access(1'b1, 1'b0, 30'h000, 32'h0);

    // Clean victim goes straight to allocate
    do_reset();
    access(1'b1, 1'b0, 30'h000, 32'h0);
    access(1'b1, 1'b0, 30'h010, 32'h0);
    access(1'b1, 1'b0, 30'h020, 32'h0);

    // Idle cycles and read+write treated as a write
    idle_cycle();
    idle_cycle();
    access(1'b1, 1'b1, 30'h021, 32'h12345678);
    access(1'b1, 1'b0, 30'h021, 32'h0);

    // Reset during ALLOCATE installs nothing
    do_reset();
    proc_read = 1'b1;
    proc_addr = 30'h004;
    @(negedge clk);
    check("rst_alloc_detect", 128'(proc_stall), 128'(1));
    @(negedge clk);
    check("rst_alloc_req", 128'({mem_read, mem_write}), 128'(2'b10));
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    proc_reset = 1'b1;
    #1;
    check_outs_zero("rst_alloc_outs");
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready  = 1'b0;
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    model_clear();
    access(1'b1, 1'b0, 30'h004, 32'h0);

    // Randomized traffic over a small tag pool to force conflicts
    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 19);
      a = {tag_pool[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (mode == 0) idle_cycle();
      else if (mode == 1 && n % 7 == 0) do_reset();
      else if (mode < 9) access(1'b1, 1'b0, a, 32'h0);
      else if (mode < 17) access(1'b0, 1'b1, a, $urandom);
      else access(1'b1, 1'b1, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
